// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of a shared single-cycle ALU.
// Accepts one operation at a time, runs it for one cycle, then holds the response until taken.
module alu_arbiter #(
    parameter int FIXED_PRIORITY = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [3:0]  req0_ctl,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [3:0]  req1_ctl,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    output logic [3:0]  alu_ctl,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    input  logic [31:0] alu_out,
    input  logic        alu_zero,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_zero,
    output logic        rsp_id,
    output logic        rsp_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state_r;
    state_t state_nxt_s;
    logic   last_grant_r;
    logic   grant_s;
    logic   accept_s;

    // Codes the shared ALU actually implements; anything else is flagged.
    function automatic logic ctl_unsupported(input logic [3:0] ctl);
        logic bad;
        case (ctl)
            4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd12, 4'd13: bad = 1'b0;
            default:                                    bad = 1'b1;
        endcase
        return bad;
    endfunction

    // Grant selection: a lone requester wins, otherwise priority or alternation.
    always_comb begin
        grant_s = 1'b0;
        if (req0_valid && req1_valid) begin
            if (FIXED_PRIORITY != 0) begin
                grant_s = 1'b0;
            end else begin
                grant_s = ~last_grant_r;
            end
        end else if (req1_valid) begin
            grant_s = 1'b1;
        end else begin
            grant_s = 1'b0;
        end
    end

    // Next-state and handshake outputs; readys only ever rise in IDLE.
    always_comb begin
        state_nxt_s = state_r;
        req0_ready  = 1'b0;
        req1_ready  = 1'b0;
        accept_s    = 1'b0;
        case (state_r)
            IDLE: begin
                req0_ready = req0_valid && !grant_s;
                req1_ready = req1_valid && grant_s;
                accept_s   = req0_ready || req1_ready;
                if (accept_s) begin
                    state_nxt_s = EXEC;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            EXEC: state_nxt_s = RESP;
            RESP: begin
                if (rsp_ready) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = RESP;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Operand capture, result capture and response handshake registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_r <= 1'b1;
            alu_ctl      <= 4'd0;
            alu_a        <= 32'd0;
            alu_b        <= 32'd0;
            rsp_valid    <= 1'b0;
            rsp_data     <= 32'd0;
            rsp_zero     <= 1'b0;
            rsp_id       <= 1'b0;
            rsp_err      <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        last_grant_r <= grant_s;
                        rsp_id       <= grant_s;
                        alu_ctl      <= grant_s ? req1_ctl : req0_ctl;
                        alu_a        <= grant_s ? req1_a   : req0_a;
                        alu_b        <= grant_s ? req1_b   : req0_b;
                    end
                end
                EXEC: begin
                    rsp_data  <= alu_out;
                    rsp_zero  <= alu_zero;
                    rsp_err   <= ctl_unsupported(alu_ctl);
                    rsp_valid <= 1'b1;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                    end
                end
                default: rsp_valid <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: a round-robin and a fixed-priority instance share stimulus,
// each driving its own behavioural model of the shared ALU.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req1_valid, rsp_ready;
    logic [3:0]  req0_ctl, req1_ctl;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;

    logic        req0_ready, req1_ready, rsp_valid, rsp_zero, rsp_id, rsp_err;
    logic [3:0]  alu_ctl;
    logic [31:0] alu_a, alu_b, alu_out, rsp_data;
    logic        alu_zero;

    logic        fp_req0_ready, fp_req1_ready, fp_rsp_valid, fp_rsp_zero, fp_rsp_id, fp_rsp_err;
    logic [3:0]  fp_alu_ctl;
    logic [31:0] fp_alu_a, fp_alu_b, fp_alu_out, fp_rsp_data;
    logic        fp_alu_zero;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] alu_model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        case (c)
            4'd0:    return a & b;
            4'd1:    return a | b;
            4'd2:    return a + b;
            4'd6:    return a - b;
            4'd7:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd12:   return ~(a | b);
            4'd13:   return a ^ b;
            default: return 32'd0;
        endcase
    endfunction

    assign alu_out     = alu_model(alu_ctl, alu_a, alu_b);
    assign alu_zero    = (alu_out == 32'd0);
    assign fp_alu_out  = alu_model(fp_alu_ctl, fp_alu_a, fp_alu_b);
    assign fp_alu_zero = (fp_alu_out == 32'd0);

    alu_arbiter #(.FIXED_PRIORITY(0)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_ctl(req0_ctl), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_ctl(req1_ctl), .req1_a(req1_a), .req1_b(req1_b),
        .alu_ctl(alu_ctl), .alu_a(alu_a), .alu_b(alu_b), .alu_out(alu_out), .alu_zero(alu_zero),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_zero(rsp_zero),
        .rsp_id(rsp_id), .rsp_err(rsp_err)
    );

    alu_arbiter #(.FIXED_PRIORITY(1)) dut_fp (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(fp_req0_ready), .req0_ctl(req0_ctl), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(fp_req1_ready), .req1_ctl(req1_ctl), .req1_a(req1_a), .req1_b(req1_b),
        .alu_ctl(fp_alu_ctl), .alu_a(fp_alu_a), .alu_b(fp_alu_b), .alu_out(fp_alu_out), .alu_zero(fp_alu_zero),
        .rsp_valid(fp_rsp_valid), .rsp_ready(rsp_ready), .rsp_data(fp_rsp_data), .rsp_zero(fp_rsp_zero),
        .rsp_id(fp_rsp_id), .rsp_err(fp_rsp_err)
    );

    task automatic test_reset;
        rst_n = 1'b0; rsp_ready = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_ctl = 4'd0; req0_a = 32'd0; req0_b = 32'd0;
        req1_ctl = 4'd0; req1_a = 32'd0; req1_b = 32'd0;
        repeat (2) @(negedge clk);
        total++;
        if ({rsp_valid, rsp_data, rsp_zero, rsp_id, rsp_err} !== 36'd0) begin
            bad++; $display("FAIL reset_rsp got=%h exp=0", {rsp_valid, rsp_data, rsp_zero, rsp_id, rsp_err});
        end
        total++;
        if ({alu_ctl, alu_a, alu_b} !== 68'd0) begin
            bad++; $display("FAIL reset_alu got=%h exp=0", {alu_ctl, alu_a, alu_b});
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_op;
        req0_valid = 1'b1; req0_ctl = 4'd2; req0_a = 32'd5; req0_b = 32'd7; rsp_ready = 1'b0;
        #1;
        total++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            bad++; $display("FAIL single_ready got=%b exp=10", {req0_ready, req1_ready});
        end
        @(negedge clk);
        req0_valid = 1'b0;
        total++;
        if ({alu_ctl, alu_a, alu_b, rsp_valid} !== {4'd2, 32'd5, 32'd7, 1'b0}) begin
            bad++; $display("FAIL single_exec got=%h/%h/%h v=%b exp=2/5/7 v=0", alu_ctl, alu_a, alu_b, rsp_valid);
        end
        @(negedge clk);
        total++;
        if ({rsp_valid, rsp_data, rsp_zero, rsp_id, rsp_err} !== {1'b1, 32'd12, 1'b0, 1'b0, 1'b0}) begin
            bad++; $display("FAIL single_rsp got v=%b d=%h z=%b id=%b e=%b exp v=1 d=c z=0 id=0 e=0",
                            rsp_valid, rsp_data, rsp_zero, rsp_id, rsp_err);
        end
    endtask

    // Starts in RESP from test_single_op; leaves the DUT having accepted requester 1.
    task automatic test_backpressure;
        req0_valid = 1'b1; req1_valid = 1'b1;
        req1_ctl = 4'd3; req1_a = 32'd1; req1_b = 32'd1;
        for (int i = 0; i < 5; i++) begin
            #1;
            total++;
            if ({rsp_valid, rsp_data, rsp_zero, rsp_id, rsp_err, req0_ready, req1_ready} !==
                {1'b1, 32'd12, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}) begin
                bad++; $display("FAIL hold_%0d got v=%b d=%h rdy=%b%b exp v=1 d=c rdy=00",
                                i, rsp_valid, rsp_data, req0_ready, req1_ready);
            end
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        #1;
        total++;
        if ({rsp_valid, rsp_data, req0_ready, req1_ready} !== {1'b0, 32'd12, 1'b0, 1'b1}) begin
            bad++; $display("FAIL release got v=%b d=%h rdy=%b%b exp v=0 d=c rdy=01",
                            rsp_valid, rsp_data, req0_ready, req1_ready);
        end
    endtask

    task automatic test_error;
        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0;
        total++;
        if (alu_ctl !== 4'd3) begin
            bad++; $display("FAIL err_ctl got=%0d exp=3", alu_ctl);
        end
        @(negedge clk);
        total++;
        if ({rsp_valid, rsp_data, rsp_zero, rsp_id, rsp_err} !== {1'b1, 32'd0, 1'b1, 1'b1, 1'b1}) begin
            bad++; $display("FAIL err_rsp got v=%b d=%h z=%b id=%b e=%b exp v=1 d=0 z=1 id=1 e=1",
                            rsp_valid, rsp_data, rsp_zero, rsp_id, rsp_err);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        total++;
        if (rsp_valid !== 1'b0) begin
            bad++; $display("FAIL err_drain got=%b exp=0", rsp_valid);
        end
    endtask

    task automatic test_alu_codes;
        logic [3:0]  c_t [6] = '{4'd0, 4'd7, 4'd12, 4'd13, 4'd15, 4'd6};
        logic [31:0] a_t [6] = '{32'h0000_F0F0, 32'd3, 32'd0, 32'hA, 32'd1, 32'd9};
        logic [31:0] b_t [6] = '{32'h0000_FF00, 32'd5, 32'd0, 32'h6, 32'd2, 32'd4};
        logic [31:0] r_t [6] = '{32'h0000_F000, 32'd1, 32'hFFFF_FFFF, 32'hC, 32'd0, 32'd5};
        logic        e_t [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 6; i++) begin
            req1_valid = 1'b1; req1_ctl = c_t[i]; req1_a = a_t[i]; req1_b = b_t[i]; rsp_ready = 1'b1;
            #1;
            total++;
            if (req1_ready !== 1'b1) begin
                bad++; $display("FAIL code_rdy_%0d got=%b exp=1", i, req1_ready);
            end
            @(negedge clk);
            req1_valid = 1'b0;
            @(negedge clk);
            total++;
            if ({rsp_valid, rsp_data, rsp_zero, rsp_id, rsp_err} !==
                {1'b1, r_t[i], (r_t[i] == 32'd0), 1'b1, e_t[i]}) begin
                bad++; $display("FAIL code_%0d got v=%b d=%h z=%b id=%b e=%b exp d=%h e=%b",
                                i, rsp_valid, rsp_data, rsp_zero, rsp_id, rsp_err, r_t[i], e_t[i]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_round_robin;
        int n = 0;
        req0_valid = 1'b1; req0_ctl = 4'd6; req0_a = 32'd3;    req0_b = 32'd3;
        req1_valid = 1'b1; req1_ctl = 4'd1; req1_a = 32'hF0; req1_b = 32'h0F;
        rsp_ready = 1'b1;
        for (int cyc = 0; cyc < 30 && n < 4; cyc++) begin
            @(negedge clk);
            total++;
            if (req0_ready && req1_ready) begin
                bad++; $display("FAIL rr_excl got=11 exp=not both");
            end
            if (rsp_valid) begin
                total++;
                if ({rsp_id, rsp_data, rsp_zero} !==
                    {n[0], (n[0] ? 32'hFF : 32'd0), ~n[0]}) begin
                    bad++; $display("FAIL rr_%0d got id=%b d=%h z=%b exp id=%b", n, rsp_id, rsp_data, rsp_zero, n[0]);
                end
                n++;
            end
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        total++;
        if (n !== 4) begin
            bad++; $display("FAIL rr_count got=%0d exp=4", n);
        end
        @(negedge clk);
    endtask

    task automatic test_fixed_priority;
        int n = 0;
        req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b1;
        for (int cyc = 0; cyc < 30 && n < 4; cyc++) begin
            @(negedge clk);
            total++;
            if (fp_req1_ready !== 1'b0) begin
                bad++; $display("FAIL fp_rdy1 got=%b exp=0", fp_req1_ready);
            end
            if (fp_rsp_valid) begin
                total++;
                if ({fp_rsp_id, fp_rsp_data, fp_rsp_zero} !== {1'b0, 32'd0, 1'b1}) begin
                    bad++; $display("FAIL fp_%0d got id=%b d=%h z=%b exp id=0 d=0 z=1", n, fp_rsp_id, fp_rsp_data, fp_rsp_zero);
                end
                n++;
            end
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        total++;
        if (n !== 4) begin
            bad++; $display("FAIL fp_count got=%0d exp=4", n);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_op;
        req0_valid = 1'b1; req0_ctl = 4'd2; req0_a = 32'd1; req0_b = 32'd1; rsp_ready = 1'b0;
        @(negedge clk);
        req0_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        total++;
        if ({rsp_valid, alu_ctl, alu_a, alu_b} !== 69'd0) begin
            bad++; $display("FAIL mid_reset got v=%b ctl=%h a=%h b=%h exp all 0", rsp_valid, alu_ctl, alu_a, alu_b);
        end
        @(negedge clk);
        rst_n = 1'b1; rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            total++;
            if (rsp_valid !== 1'b0) begin
                bad++; $display("FAIL ghost_rsp_%0d got=1 exp=0", i);
            end
        end
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        total++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            bad++; $display("FAIL post_reset_grant got=%b exp=10", {req0_ready, req1_ready});
        end
        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0;
    endtask

    initial begin
        test_reset;
        test_single_op;
        test_backpressure;
        test_error;
        test_alu_codes;
        test_round_robin;
        test_fixed_priority;
        test_reset_mid_op;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
